// File: rtl/psr_ctrl.sv
// Write controller for the 5-bit processor status register: arbitrates interrupt
// entry/exit, software move-to-PSR and ALU flag updates, with a shadow stack for nesting.
module psr_ctrl #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       alu_valid,
   input  logic [4:0]                 alu_mask,
   input  logic [4:0]                 alu_flags,
   output logic                       alu_grant,
   input  logic                       mv_valid,
   input  logic [4:0]                 mv_data,
   output logic                       mv_grant,
   input  logic                       int_enter,
   input  logic                       int_exit,
   input  logic [4:0]                 psr_q,
   output logic [4:0]                 psrWrEn,
   output logic [4:0]                 psrWrite,
   output logic                       stall,
   output logic [$clog2(DEPTH+1)-1:0] depth,
   output logic                       err_ovf,
   output logic                       err_unf,
   output logic [1:0]                 stateDbg
);

   // Handshake: a valid requester holds valid high; the request is consumed in any
   // cycle where its grant is high (both combinational in the same cycle).

   localparam int DW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SAVE    = 2'd1,
      CLEAR   = 2'd2,
      RESTORE = 2'd3
   } stateT;

   stateT         state;
   stateT         nextState;
   logic [4:0]    shadow [0:(1<<AW)-1];
   logic [4:0]    wrEnNext;
   logic [4:0]    writeNext;
   logic [DW-1:0] depthNext;
   logic          ovfNext;
   logic          unfNext;
   logic          pushEn;
   logic [AW-1:0] pushIdx;
   logic [AW-1:0] topIdx;

   assign pushIdx  = depth[AW-1:0];
   assign topIdx   = AW'(depth - DW'(1));
   assign stall    = (state != IDLE);
   assign stateDbg = state;

   always_comb begin
      nextState = state;
      wrEnNext  = 5'b00000;
      writeNext = 5'b00000;
      depthNext = depth;
      ovfNext   = err_ovf;
      unfNext   = err_unf;
      pushEn    = 1'b0;
      alu_grant = 1'b0;
      mv_grant  = 1'b0;
      case (state)
         IDLE: begin
            // Any interrupt pulse blocks both grants, even an exit that underflows.
            if (int_enter) begin
               nextState = SAVE;
            end else if (int_exit) begin
               if (depth != DW'(0)) begin
                  wrEnNext  = 5'b11111;
                  writeNext = shadow[topIdx];
                  depthNext = depth - DW'(1);
                  nextState = RESTORE;
               end else begin
                  unfNext = 1'b1;
               end
            end else if (mv_valid) begin
               mv_grant  = 1'b1;
               wrEnNext  = 5'b11111;
               writeNext = mv_data;
            end else if (alu_valid) begin
               alu_grant = 1'b1;
               wrEnNext  = alu_mask;
               writeNext = alu_flags;
            end
         end
         SAVE: begin
            if (depth == DW'(DEPTH)) begin
               ovfNext = 1'b1;
            end else begin
               pushEn    = 1'b1;
               depthNext = depth + DW'(1);
            end
            wrEnNext  = 5'b11111;
            writeNext = 5'b00000;
            nextState = CLEAR;
         end
         CLEAR:   nextState = IDLE;
         RESTORE: nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         psrWrEn  <= 5'b00000;
         psrWrite <= 5'b00000;
         depth    <= '0;
         err_ovf  <= 1'b0;
         err_unf  <= 1'b0;
      end else begin
         state    <= nextState;
         psrWrEn  <= wrEnNext;
         psrWrite <= writeNext;
         depth    <= depthNext;
         err_ovf  <= ovfNext;
         err_unf  <= unfNext;
      end
   end

   // Entries above depth are don't-care, so the stack itself needs no reset.
   always_ff @(posedge clk) begin
      if (pushEn) begin
         shadow[pushIdx] <= psr_q;
      end
   end

endmodule
